// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: control/status bit indices and default sizes.
package uart_pkg;

  localparam int CR_RE   = 0;
  localparam int CR_THIE = 1;
  localparam int CR_TOIE = 4;

  localparam int ST_NE  = 0;
  localparam int ST_FE  = 1;
  localparam int ST_PE  = 2;
  localparam int ST_OVR = 3;

  localparam int DEFAULT_DEPTH = 16;
  localparam int BYTE_W        = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an independent occupancy counter and synchronous flush.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = BYTE_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] head,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A full FIFO still takes a push when the same cycle pops the head.
  assign pop_ok  = pop & ~flush & ~empty;
  assign push_ok = push & ~flush & (~full | pop_ok);

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receive buffer: byte FIFO, sticky error status and interrupt request.
// Optional idle-timeout interrupt is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int RX_THRESH = 8,
  parameter int TO_CYCLES = 50000,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic        clock_125,
  input  logic        rst_n_125,
  input  logic [11:0] uart_cr,
  input  logic [7:0]  po_data,
  input  logic        po_flag,
  input  logic        ne_flag,
  input  logic        fe_flag,
  input  logic        pe_flag,
  input  logic        rd_en,
  input  logic        fifo_flush,
  input  logic [3:0]  status_clr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [AW:0] fifo_level,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [3:0]  rx_status,
  output logic        rx_irq
);

  logic       push_req;
  logic       pop_ok;
  logic       push_ok;
  logic       ovr_evt;
  logic [7:0] head;
  logic [3:0] err_set;
  logic       to_req;
  logic       unused_cfg;

  assign push_req = po_flag & uart_cr[CR_RE] & ~fifo_flush;
  assign pop_ok   = rd_en & ~fifo_empty & ~fifo_flush;
  assign push_ok  = push_req & (~fifo_full | pop_ok);
  assign ovr_evt  = push_req & fifo_full & ~pop_ok;

  uart_sync_fifo #(
    .DATA_W (BYTE_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clock_125),
    .rst_n   (rst_n_125),
    .push    (push_ok),
    .pop     (pop_ok),
    .flush   (fifo_flush),
    .wr_data (po_data),
    .head    (head),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    err_set          = '0;
    err_set[ST_NE]   = ne_flag;
    err_set[ST_FE]   = fe_flag;
    err_set[ST_PE]   = pe_flag;
    err_set[ST_OVR]  = ovr_evt;
  end

  // Read port and status: rd_data holds its last value between pops.
  always_ff @(posedge clock_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rx_status <= '0;
      rx_irq    <= 1'b0;
    end else begin
      rd_valid  <= pop_ok;
      if (pop_ok) rd_data <= head;
      rx_status <= (rx_status & ~status_clr) | err_set;
      rx_irq    <= (uart_cr[CR_THIE] & (fifo_level >= (AW+1)'(RX_THRESH)))
                 | (|rx_status) | to_req;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timeout_irq;

  // Counter saturates at the limit so the flag cannot re-arm by wrapping.
  always_ff @(posedge clock_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      idle_cnt    <= '0;
      timeout_irq <= 1'b0;
    end else begin
      if (push_ok || pop_ok || fifo_flush || fifo_empty)
        idle_cnt <= '0;
      else if (idle_cnt != 32'(TO_CYCLES))
        idle_cnt <= idle_cnt + 32'd1;
      if (pop_ok || fifo_flush)
        timeout_irq <= 1'b0;
      else if (idle_cnt == 32'(TO_CYCLES))
        timeout_irq <= 1'b1;
    end
  end

  assign to_req     = timeout_irq & uart_cr[CR_TOIE];
  assign unused_cfg = ^{uart_cr[11:5], uart_cr[3:2]};
`else
  assign to_req     = 1'b0;
  assign unused_cfg = ^{uart_cr[11:5], uart_cr[4:2], 32'(TO_CYCLES)};
`endif

endmodule
